// File: rtl/prover_addtree_tagged.sv
// Registered modular adder tree: ngates field elements reduced mod `F_Q, final sum
// latched into a per-tag result register so even/odd product passes sit side by side.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module prover_addtree_tagged #(
    parameter int ngates  = 4,
    parameter int nlevels = $clog2(ngates)
) (
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               en,
    input  logic                               tag_in,
    input  logic [ngates-1:0][`F_NBITS-1:0]    vals_in,
    output logic                               ready,
    output logic                               ready_pulse,
    output logic [`F_NBITS-1:0]                sum_out,
    output logic                               tag_out,
    output logic [`F_NBITS-1:0]                sum_tag0,
    output logic [`F_NBITS-1:0]                sum_tag1
);
    localparam int W  = `F_NBITS;
    localparam int NP = 1 << nlevels;
    localparam int NN = 2 * NP - 1;
    localparam logic [W-1:0] Q = `F_Q;

    generate
        if (ngates < 1 || nlevels != $clog2(ngates)) begin : g_param_check
            $error("prover_addtree_tagged: ngates must be >= 1 and nlevels must not be overridden");
        end
    endgenerate

    // Tree nodes in heap order: level k occupies NP>>k entries starting at lvl_off(k).
    logic [W-1:0]     r_node [NN];
    logic [nlevels:0] r_valid;
    logic [nlevels:0] r_tag;
    logic             r_ready_dly;
    logic             w_accept;

    function automatic int lvl_off(input int k);
        return 2 * NP - 2 * (NP >> k);
    endfunction

    function automatic logic [W-1:0] modadd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    always_comb begin
        ready       = (r_valid == '0);
        w_accept    = en & ready;
        ready_pulse = ready & ~r_ready_dly;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned i = 0; i < ngates; i++) r_node[i] <= vals_in[i];
            for (int unsigned i = ngates; i < NP; i++) r_node[i] <= '0;
        end
        for (int unsigned k = 1; k <= nlevels; k++) begin
            for (int unsigned i = 0; i < (NP >> k); i++) begin
                r_node[lvl_off(k) + i] <= modadd(r_node[lvl_off(k - 1) + 2 * i],
                                                 r_node[lvl_off(k - 1) + 2 * i + 1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_valid     <= '0;
            r_tag       <= '0;
            r_ready_dly <= 1'b1;
            sum_out     <= '0;
            tag_out     <= 1'b0;
            sum_tag0    <= '0;
            sum_tag1    <= '0;
        end else begin
            r_ready_dly <= ready;
            r_valid[0]  <= w_accept;
            if (w_accept) r_tag[0] <= tag_in;
            for (int unsigned k = 1; k <= nlevels; k++) begin
                r_valid[k] <= r_valid[k - 1];
                r_tag[k]   <= r_tag[k - 1];
            end
            if (r_valid[nlevels]) begin
                sum_out <= r_node[NN - 1];
                tag_out <= r_tag[nlevels];
                if (r_tag[nlevels]) sum_tag1 <= r_node[NN - 1];
                else                sum_tag0 <= r_node[NN - 1];
            end
        end
    end
endmodule

// File: tb/tb_prover_addtree_tagged.sv
// Directed scoreboard bench for prover_addtree_tagged (ngates = 4, 3 and 1 instances).
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_prover_addtree_tagged;
    localparam int W = `F_NBITS;
    localparam logic [W-1:0] Q = `F_Q;

    typedef struct {
        int           sel;
        logic         tag;
        logic [W-1:0] sum;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic [W-1:0] m_t0 [3];
    logic [W-1:0] m_t1 [3];

    logic clk = 1'b0;
    logic rstb;
    logic en4, en3, en1, tag4, tag3, tag1;
    logic [3:0][W-1:0] vals4;
    logic [2:0][W-1:0] vals3;
    logic [0:0][W-1:0] vals1;
    logic rdy4, rdy3, rdy1, rp4, rp3, rp1, to4, to3, to1;
    logic [W-1:0] so4, so3, so1, s04, s03, s01, s14, s13, s11;

    always #5 clk = ~clk;

    prover_addtree_tagged #(.ngates(4)) dut4 (
        .clk(clk), .rstb(rstb), .en(en4), .tag_in(tag4), .vals_in(vals4),
        .ready(rdy4), .ready_pulse(rp4), .sum_out(so4), .tag_out(to4),
        .sum_tag0(s04), .sum_tag1(s14));
    prover_addtree_tagged #(.ngates(3)) dut3 (
        .clk(clk), .rstb(rstb), .en(en3), .tag_in(tag3), .vals_in(vals3),
        .ready(rdy3), .ready_pulse(rp3), .sum_out(so3), .tag_out(to3),
        .sum_tag0(s03), .sum_tag1(s13));
    prover_addtree_tagged #(.ngates(1)) dut1 (
        .clk(clk), .rstb(rstb), .en(en1), .tag_in(tag1), .vals_in(vals1),
        .ready(rdy1), .ready_pulse(rp1), .sum_out(so1), .tag_out(to1),
        .sum_tag0(s01), .sum_tag1(s11));

    function automatic logic f_ready(input int s);
        case (s) 0: return rdy4; 1: return rdy3; default: return rdy1; endcase
    endfunction
    function automatic logic f_pulse(input int s);
        case (s) 0: return rp4; 1: return rp3; default: return rp1; endcase
    endfunction
    function automatic logic f_tag(input int s);
        case (s) 0: return to4; 1: return to3; default: return to1; endcase
    endfunction
    function automatic logic [W-1:0] f_sum(input int s);
        case (s) 0: return so4; 1: return so3; default: return so1; endcase
    endfunction
    function automatic logic [W-1:0] f_t0(input int s);
        case (s) 0: return s04; 1: return s03; default: return s01; endcase
    endfunction
    function automatic logic [W-1:0] f_t1(input int s);
        case (s) 0: return s14; 1: return s13; default: return s11; endcase
    endfunction

    // Reference: plain wide sum then a single reduction, independent of any tree shape.
    function automatic logic [W-1:0] refsum(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W+2:0] t;
        t = (W+3)'(a) + (W+3)'(b) + (W+3)'(c) + (W+3)'(d);
        return W'(t % (W+3)'(Q));
    endfunction

    task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic start4(input logic [W-1:0] a, b, c, d, input logic t);
        exp_t e;
        vals4[0] = a; vals4[1] = b; vals4[2] = c; vals4[3] = d;
        tag4 = t; en4 = 1'b1;
        e.sel = 0; e.tag = t; e.sum = refsum(a, b, c, d);
        q.push_back(e);
    endtask

    task automatic start3(input logic [W-1:0] a, b, c, input logic t);
        exp_t e;
        vals3[0] = a; vals3[1] = b; vals3[2] = c;
        tag3 = t; en3 = 1'b1;
        e.sel = 1; e.tag = t; e.sum = refsum(a, b, c, '0);
        q.push_back(e);
    endtask

    task automatic start1(input logic [W-1:0] a, input logic t);
        exp_t e;
        vals1[0] = a; tag1 = t; en1 = 1'b1;
        e.sel = 2; e.tag = t; e.sum = a;
        q.push_back(e);
    endtask

    // Called at the negedge right after the accept edge; returns at the ready_pulse negedge.
    task automatic wait_done(input int sel, input int lat);
        int   n = 0;
        exp_t e;
        while (f_pulse(sel) !== 1'b1 && n < 20) begin
            chk("busy_ready_low", W'(f_ready(sel)), '0);
            if (sel == 0 && n == 1) begin
                chk("lvl1_node4_lt_q", W'(dut4.r_node[4] < Q), W'(1));
                chk("lvl1_node5_lt_q", W'(dut4.r_node[5] < Q), W'(1));
            end
            if (sel == 0 && n == 2) chk("lvl2_node6_lt_q", W'(dut4.r_node[6] < Q), W'(1));
            @(negedge clk);
            n++;
        end
        chk("latency", W'(n), W'(lat));
        chk("ready_at_pulse", W'(f_ready(sel)), W'(1));
        chk("sb_nonempty", W'(q.size() != 0), W'(1));
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.tag) m_t1[sel] = e.sum;
            else       m_t0[sel] = e.sum;
            chk("sum_out", f_sum(sel), e.sum);
            chk("tag_out", W'(f_tag(sel)), W'(e.tag));
            chk("sum_tag0", f_t0(sel), m_t0[sel]);
            chk("sum_tag1", f_t1(sel), m_t1[sel]);
        end
    endtask

    task automatic post_idle(input int sel);
        @(negedge clk);
        chk("single_pulse", W'(f_pulse(sel)), '0);
        chk("ready_hold", W'(f_ready(sel)), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        en4 = 1'b0; en3 = 1'b0; en1 = 1'b0;
        tag4 = 1'b0; tag3 = 1'b0; tag1 = 1'b0;
        vals4 = '0; vals3 = '0; vals1 = '0;
        for (int s = 0; s < 3; s++) begin m_t0[s] = '0; m_t1[s] = '0; end
        repeat (2) @(negedge clk);
        rstb = 1'b1;

        // Idle after reset
        repeat (4) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                chk("idle_ready", W'(f_ready(s)), W'(1));
                chk("idle_pulse", W'(f_pulse(s)), '0);
                chk("idle_sum", f_sum(s), '0);
                chk("idle_tag", W'(f_tag(s)), '0);
                chk("idle_t0", f_t0(s), '0);
                chk("idle_t1", f_t1(s), '0);
            end
        end

        // Basic {1,2,3,4} tag 1
        start4(1, 2, 3, 4, 1'b1);
        @(negedge clk); en4 = 1'b0;
        wait_done(0, 3);
        post_idle(0);

        // Wrap: {Q-1,Q-1,1,0} tag 0
        @(negedge clk);
        start4(Q - 1, Q - 1, 1, 0, 1'b0);
        @(negedge clk); en4 = 1'b0;
        wait_done(0, 3);
        post_idle(0);

        // Two passes
        start4(5, 5, 5, 5, 1'b1);
        @(negedge clk); en4 = 1'b0;
        wait_done(0, 3);
        post_idle(0);
        start4(1, 1, 1, 1, 1'b0);
        @(negedge clk); en4 = 1'b0;
        wait_done(0, 3);
        post_idle(0);

        // Busy: en held high with junk inputs, re-accept right after ready rises
        start4(Q - 2, 3, Q - 1, 7, 1'b1);
        @(negedge clk);
        vals4 = '1; tag4 = 1'b0;
        wait_done(0, 3);
        start4(9, 9, 9, 9, 1'b0);
        @(negedge clk); en4 = 1'b0;
        wait_done(0, 3);
        post_idle(0);

        // ngates = 3 (zero padding) and ngates = 1 (pass-through)
        start3(7, 8, 9, 1'b1);
        @(negedge clk); en3 = 1'b0;
        wait_done(1, 3);
        post_idle(1);
        start1(42, 1'b0);
        @(negedge clk); en1 = 1'b0;
        wait_done(2, 1);
        post_idle(2);

        // Reset mid-operation
        start4(11, 22, 33, 44, 1'b1);
        @(negedge clk); en4 = 1'b0;
        rstb = 1'b0;
        #1;
        q.delete();
        for (int s = 0; s < 3; s++) begin m_t0[s] = '0; m_t1[s] = '0; end
        chk("rst_sum", so4, '0);
        chk("rst_t0", s04, '0);
        chk("rst_t1", s14, '0);
        chk("rst_tag", W'(to4), '0);
        chk("rst_ready", W'(rdy4), W'(1));
        @(negedge clk);
        rstb = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_pulse", W'(rp4), '0);
            chk("post_rst_sum", so4, '0);
            chk("post_rst_ready", W'(rdy4), W'(1));
        end

        // Recovery after reset
        start4(100, 200, 300, 400, 1'b0);
        @(negedge clk); en4 = 1'b0;
        wait_done(0, 3);
        post_idle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
